// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter.
// Owner tags and access-size encodings.
package mem_req_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } mem_src_t;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// 1-bit owner FIFO: records who issued each accepted request.
// Ports: clk, reset, push/push_src, pop, head, full, empty.
import mem_req_arbiter_pkg::*;

module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  mem_src_t push_src,
  input  logic     pop,
  output mem_src_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push_e;
  logic             pop_e;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign push_e = push & ~full;
  assign pop_e  = pop & ~empty;
  assign head   = mem_src_t'(mem[rd_ptr]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_e) begin
        mem[wr_ptr] <= push_src;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_e)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_e, pop_e})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one downstream req/addr_ok/data_ok port between fetch and data.
// Ports: i_* fetch side, d_* data side, m_* downstream, proto_err sticky.
import mem_req_arbiter_pkg::*;

module mem_req_arbiter #(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [3:0]        d_wstrb,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [3:0]        m_wstrb,
  output logic [31:0]       m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              proto_err
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic       run;
  logic       grant_inst;
  logic       grant_data;
  logic       accept;
  logic       q_full;
  logic       q_empty;
  mem_src_t   q_head;
  mem_src_t   push_src;
  logic [7:0] starve_cnt;

  // Outputs are forced low the instant reset rises, not at the next edge.
  assign run = ~reset;

  assign grant_inst = run & i_req
                    & (~d_req | (starve_cnt == LIMIT));
  assign grant_data = run & d_req & ~grant_inst;

  assign m_req  = run & (i_req | d_req) & ~q_full;
  assign accept = m_req & m_addr_ok;

  assign i_addr_ok = accept & grant_inst;
  assign d_addr_ok = accept & grant_data;

  assign push_src = grant_inst ? SRC_INST : SRC_DATA;

  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_wstrb = 4'd0;
    m_addr  = 32'd0;
    m_wdata = '0;
    unique case (1'b1)
      grant_inst: begin
        m_size = MEM_SIZE_W;
        m_addr = i_addr;
      end
      grant_data: begin
        m_wr    = d_wr;
        m_size  = d_size;
        m_wstrb = d_wstrb;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_src(push_src),
    .pop     (m_data_ok),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign i_data_ok = run & m_data_ok & ~q_empty
                   & (q_head == SRC_INST);
  assign d_data_ok = run & m_data_ok & ~q_empty
                   & (q_head == SRC_DATA);
  assign i_rdata   = run ? m_rdata : '0;
  assign d_rdata   = run ? m_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (accept) begin
      if (grant_data & i_req) begin
        if (starve_cnt != LIMIT)
          starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'd0;
      end
    end
  end

  // Orphan response: nothing outstanding to route it to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      proto_err <= 1'b0;
    else if (m_data_ok & q_empty)
      proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: queue-based reference model,
// directed scenarios and randomized traffic.
module tb_mem_req_arbiter;

  localparam int MAXO = 4;
  localparam int LIM  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        proto_err;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .DATA_W(32), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size),
    .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .proto_err(proto_err)
  );

  // reference model state: 0 = fetch owns entry, 1 = data
  bit q[$];
  int cnt;
  bit perr;

  int n_chk  = 0;
  int n_fail = 0;

  // snapshots of DUT outputs taken at the last check point
  logic        s_i_addr_ok, s_d_addr_ok, s_m_req;
  logic        s_i_data_ok, s_d_data_ok, s_perr, s_m_wr;
  logic [1:0]  s_m_size;
  logic [3:0]  s_m_wstrb;
  logic [31:0] s_m_addr, s_m_wdata, s_i_rdata;

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endfunction

  task automatic model_reset();
    q.delete();
    cnt  = 0;
    perr = 0;
  endtask

  task automatic tick();
    bit full, gi, gd, mreq, acc;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic        e_wr;
    #3;
    full = (q.size() >= MAXO);
    gi   = i_req && (!d_req || cnt == LIM);
    gd   = d_req && !gi;
    mreq = (i_req || d_req) && !full;
    acc  = mreq && m_addr_ok;
    e_addr = 0; e_wdata = 0; e_size = 0;
    e_wstrb = 0; e_wr = 0;
    if (gi) begin
      e_addr = i_addr; e_size = 2;
    end else if (gd) begin
      e_addr = d_addr; e_wdata = d_wdata; e_size = d_size;
      e_wstrb = d_wstrb; e_wr = d_wr;
    end
    chk("m_req", 32'(m_req), 32'(mreq));
    chk("i_addr_ok", 32'(i_addr_ok), 32'(acc && gi));
    chk("d_addr_ok", 32'(d_addr_ok), 32'(acc && gd));
    if (mreq) begin
      chk("m_addr", m_addr, e_addr);
      chk("m_wr", 32'(m_wr), 32'(e_wr));
      chk("m_size", 32'(m_size), 32'(e_size));
      chk("m_wstrb", 32'(m_wstrb), 32'(e_wstrb));
      chk("m_wdata", m_wdata, e_wdata);
    end
    chk("i_data_ok", 32'(i_data_ok),
        32'(m_data_ok && q.size() > 0 && q[0] == 0));
    chk("d_data_ok", 32'(d_data_ok),
        32'(m_data_ok && q.size() > 0 && q[0] == 1));
    chk("i_rdata", i_rdata, m_rdata);
    chk("d_rdata", d_rdata, m_rdata);
    chk("proto_err", 32'(proto_err), 32'(perr));
    s_i_addr_ok = i_addr_ok; s_d_addr_ok = d_addr_ok;
    s_m_req = m_req; s_i_data_ok = i_data_ok;
    s_d_data_ok = d_data_ok; s_perr = proto_err;
    s_m_wr = m_wr; s_m_size = m_size; s_m_wstrb = m_wstrb;
    s_m_addr = m_addr; s_m_wdata = m_wdata;
    s_i_rdata = i_rdata;
    @(posedge clk);
    if (m_data_ok) begin
      if (q.size() == 0) perr = 1;
      else void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(gd);
      if (gi) cnt = 0;
      else if (i_req) cnt = (cnt < LIM) ? cnt + 1 : LIM;
      else cnt = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_wr = 0; d_size = 0;
    d_wstrb = 0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic drain();
    idle_inputs();
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      m_data_ok = 1;
      tick();
    end
    m_data_ok = 0;
  endtask

  initial begin
    int first_f, n_f, n_d;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    idle_inputs();
    reset = 1;
    #2;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();

    // single fetch, response two cycles later
    i_req = 1; i_addr = 32'h1c00_0000; m_addr_ok = 1;
    tick();
    chk("t1_i_addr_ok", 32'(s_i_addr_ok), 32'd1);
    chk("t1_m_addr", s_m_addr, 32'h1c00_0000);
    chk("t1_m_wr", 32'(s_m_wr), 32'd0);
    idle_inputs();
    tick();
    m_data_ok = 1; m_rdata = 32'h0280_0000;
    tick();
    chk("t1_i_data_ok", 32'(s_i_data_ok), 32'd1);
    chk("t1_i_rdata", s_i_rdata, 32'h0280_0000);
    chk("t1_d_data_ok", 32'(s_d_data_ok), 32'd0);
    idle_inputs();

    // starvation guard
    do_reset();
    i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h80;
    m_addr_ok = 1;
    first_f = 0; n_f = 0; n_d = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      m_data_ok = 1;
      if (s_i_addr_ok) begin
        n_f++;
        if (first_f == 0) first_f = k;
      end
      if (s_d_addr_ok) n_d++;
    end
    chk("starve_first_fetch", 32'(first_f), 32'd9);
    chk("starve_fetch_cnt", 32'(n_f), 32'd1);
    chk("starve_data_cnt", 32'(n_d), 32'd13);
    drain();

    // fetch, data, fetch then in-order responses
    m_addr_ok = 1;
    i_req = 1; tick();
    i_req = 0; d_req = 1; tick();
    d_req = 0; i_req = 1; tick();
    idle_inputs();
    m_data_ok = 1;
    tick();
    chk("ord_0_i", 32'(s_i_data_ok), 32'd1);
    tick();
    chk("ord_1_d", 32'(s_d_data_ok), 32'd1);
    tick();
    chk("ord_2_i", 32'(s_i_data_ok), 32'd1);
    chk("ord_2_d", 32'(s_d_data_ok), 32'd0);
    idle_inputs();

    // queue full blocks m_req
    do_reset();
    i_req = 1; m_addr_ok = 1;
    repeat (4) tick();
    d_req = 1;
    tick();
    chk("full_m_req", 32'(s_m_req), 32'd0);
    chk("full_i_ok", 32'(s_i_addr_ok), 32'd0);
    chk("full_d_ok", 32'(s_d_addr_ok), 32'd0);
    m_data_ok = 1;
    tick();
    chk("full_pop_m_req", 32'(s_m_req), 32'd0);
    m_data_ok = 0;
    tick();
    chk("full_after_m_req", 32'(s_m_req), 32'd1);
    drain();

    // stalled write holds fields stable
    d_req = 1; d_wr = 1; d_wstrb = 4'h3; d_size = 2'd1;
    d_wdata = 32'h1234; d_addr = 32'h2000; m_addr_ok = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wr_stall_ok", 32'(s_d_addr_ok), 32'd0);
      chk("wr_wstrb", 32'(s_m_wstrb), 32'h3);
      chk("wr_size", 32'(s_m_size), 32'd1);
      chk("wr_wdata", s_m_wdata, 32'h1234);
    end
    m_addr_ok = 1;
    tick();
    chk("wr_accept", 32'(s_d_addr_ok), 32'd1);
    idle_inputs();
    m_data_ok = 1;
    tick();
    chk("wr_resp", 32'(s_d_data_ok), 32'd1);
    idle_inputs();

    // randomized legal traffic
    for (int k = 0; k < 3000; k++) begin
      i_req = ($urandom_range(0, 9) < 6);
      d_req = ($urandom_range(0, 9) < 6);
      i_addr = $urandom; d_addr = $urandom;
      d_wdata = $urandom; d_wr = 1'($urandom);
      d_size = 2'($urandom_range(0, 2));
      d_wstrb = 4'($urandom);
      m_addr_ok = ($urandom_range(0, 9) < 7);
      m_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rdata = $urandom;
      tick();
    end
    drain();

    // orphan response sets sticky error
    m_data_ok = 1;
    tick();
    chk("perr_same_cycle", 32'(s_perr), 32'd0);
    m_data_ok = 0;
    tick();
    chk("perr_set", 32'(s_perr), 32'd1);
    for (int k = 0; k < 200; k++) begin
      i_req = 1'($urandom); d_req = 1'($urandom);
      i_addr = $urandom; d_addr = $urandom;
      m_addr_ok = 1'($urandom);
      m_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("perr_sticky", 32'(s_perr), 32'd1);

    // asynchronous mid-cycle reset
    idle_inputs();
    i_req = 1;
    #3;
    reset = 1;
    #1;
    chk("async_perr", 32'(proto_err), 32'd0);
    chk("async_m_req", 32'(m_req), 32'd0);
    chk("async_i_addr_ok", 32'(i_addr_ok), 32'd0);
    @(posedge clk);
    #2;
    idle_inputs();
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    i_req = 1; m_addr_ok = 1;
    tick();
    chk("post_rst_accept", 32'(s_i_addr_ok), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
